// File: rtl/ram_sync_access_ctrl.sv
// ram_sync_access_ctrl: burst controller in front of a single-port synchronous RAM.
// Accepts write/read bursts (start address plus beats-minus-one) and sequences
// the RAM address, data and write enable one beat at a time.
// Optional feature: define RAM_CTRL_BOUNDS_EN to reject bursts that would run
// past the top of the RAM (err pulse, no RAM access) instead of wrapping.
module ram_sync_access_ctrl #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [AWIDTH-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_ADDR = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH-1:0] count;
  logic [AWIDTH-1:0] len;
  logic              accept;
  logic              reject;
  logic              wr_beat;

  assign accept  = req_valid && req_ready;
  assign wr_beat = wr_valid && wr_ready;

`ifdef RAM_CTRL_BOUNDS_EN
  // Carry out of the one-bit-wider sum means the last beat lands past DEPTH-1.
  logic [AWIDTH:0] end_addr;
  assign end_addr = {1'b0, req_addr} + {1'b0, req_len};
  assign reject   = end_addr[AWIDTH];
`else
  assign reject = 1'b0;
`endif

  // RAM side: address comes straight from the burst pointer register; the write
  // strobe follows the beat handshake so a stalled beat never touches the RAM,
  // and reset masks it so an abandoned burst cannot write on the reset edge.
  assign ram_addr = cur_addr;
  assign ram_we   = wr_beat && !reset;
  assign ram_din  = (wr_ready && !reset) ? wr_data : '0;

  // Read data is the RAM output; the address is held in RD_RESP so it stays stable.
  assign rd_data = ram_dout;

  // Burst sequencer: state, pointers and registered handshake/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cur_addr  <= '0;
      count     <= '0;
      len       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              cur_addr  <= req_addr;
              len       <= req_len;
              count     <= '0;
              req_ready <= 1'b0;
              if (req_write) begin
                state    <= WRITE;
                wr_ready <= 1'b1;
              end else begin
                state <= RD_ADDR;
              end
            end
          end
        end

        WRITE: begin
          if (wr_beat) begin
            cur_addr <= cur_addr + AWIDTH'(1);
            count    <= count + AWIDTH'(1);
            if (count == len) begin
              state     <= IDLE;
              wr_ready  <= 1'b0;
              req_ready <= 1'b1;
              done      <= 1'b1;
            end
          end
        end

        RD_ADDR: begin
          state    <= RD_RESP;
          rd_valid <= 1'b1;
          rd_last  <= (count == len);
        end

        RD_RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_last) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              done      <= 1'b1;
            end else begin
              cur_addr <= cur_addr + AWIDTH'(1);
              count    <= count + AWIDTH'(1);
              state    <= RD_ADDR;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_access_ctrl.sv
// Directed bench for ram_sync_access_ctrl with a behavioural synchronous RAM.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
module tb_ram_sync_access_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;
  logic          err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [8];
  int            wr_count;
  int            checks;
  int            failures;
  int            base;

  ram_sync_access_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done),
    .err      (err),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: dout reflects the address presented in the previous cycle.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    ram_dout = '0;
    wr_count = 0;
  end

  always @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_count      <= wr_count + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Present a request for one cycle; returns at the falling edge after acceptance.
  task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_ready",  32'(wr_ready),  32'd0);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_rd_last",   32'(rd_last),   32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_ram_addr",  32'(ram_addr),  32'd0);
    chk("rst_ram_din",   ram_din,        32'd0);
    reset = 1'b0;
    tick(); #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);

    // Write burst addr=2 len=2, data A,B,C back-to-back
    send_req(1'b1, 3'd2, 3'd2);
    chk("w1_req_ready", 32'(req_ready), 32'd0);
    chk("w1_wr_ready",  32'(wr_ready),  32'd1);
    wr_valid = 1'b1; wr_data = 32'hA; #1;
    chk("w1_we0",   32'(ram_we),   32'd1);
    chk("w1_addr0", 32'(ram_addr), 32'd2);
    chk("w1_din0",  ram_din,       32'hA);
    tick(); wr_data = 32'hB; #1;
    chk("w1_we1",   32'(ram_we),   32'd1);
    chk("w1_addr1", 32'(ram_addr), 32'd3);
    chk("w1_din1",  ram_din,       32'hB);
    tick(); wr_data = 32'hC; #1;
    chk("w1_we2",   32'(ram_we),   32'd1);
    chk("w1_addr2", 32'(ram_addr), 32'd4);
    chk("w1_done_early", 32'(done), 32'd0);
    tick(); wr_valid = 1'b0; #1;
    chk("w1_done",      32'(done),      32'd1);
    chk("w1_we_after",  32'(ram_we),    32'd0);
    chk("w1_wr_ready0", 32'(wr_ready),  32'd0);
    chk("w1_idle",      32'(req_ready), 32'd1);
    chk("w1_err",       32'(err),       32'd0);
    tick(); #1;
    chk("w1_done_pulse", 32'(done), 32'd0);

    // Read burst addr=2 len=2, rd_ready=1: A,B,C every other cycle
    rd_ready = 1'b1;
    send_req(1'b0, 3'd2, 3'd2);
    chk("r1_addr_phase_valid", 32'(rd_valid), 32'd0);
    chk("r1_addr_phase_addr",  32'(ram_addr), 32'd2);
    chk("r1_addr_phase_we",    32'(ram_we),   32'd0);
    tick(); #1;
    chk("r1_v0",    32'(rd_valid), 32'd1);
    chk("r1_d0",    rd_data,       32'hA);
    chk("r1_last0", 32'(rd_last),  32'd0);
    tick(); #1;
    chk("r1_gap0",  32'(rd_valid), 32'd0);
    chk("r1_addr1", 32'(ram_addr), 32'd3);
    tick(); #1;
    chk("r1_v1",    32'(rd_valid), 32'd1);
    chk("r1_d1",    rd_data,       32'hB);
    chk("r1_last1", 32'(rd_last),  32'd0);
    tick(); #1;
    chk("r1_gap1",  32'(rd_valid), 32'd0);
    tick(); #1;
    chk("r1_v2",    32'(rd_valid), 32'd1);
    chk("r1_d2",    rd_data,       32'hC);
    chk("r1_last2", 32'(rd_last),  32'd1);
    chk("r1_done_early", 32'(done), 32'd0);
    tick(); #1;
    chk("r1_done",  32'(done),     32'd1);
    chk("r1_v_end", 32'(rd_valid), 32'd0);
    tick(); #1;
    chk("r1_done_pulse", 32'(done), 32'd0);

    // Single-beat read with back-pressure: data held, no done until consumed
    rd_ready = 1'b0;
    send_req(1'b0, 3'd4, 3'd0);
    tick(); #1;
    chk("r2_v",    32'(rd_valid), 32'd1);
    chk("r2_last", 32'(rd_last),  32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("r2_hold_valid", 32'(rd_valid), 32'd1);
      chk("r2_hold_data",  rd_data,       32'hC);
      chk("r2_hold_done",  32'(done),     32'd0);
    end
    rd_ready = 1'b1;
    tick(); rd_ready = 1'b0; #1;
    chk("r2_done",  32'(done),     32'd1);
    chk("r2_v_end", 32'(rd_valid), 32'd0);
    tick(); #1;

    // Burst crossing the top of the RAM: addr=6 len=3
    base = wr_count;
`ifdef RAM_CTRL_BOUNDS_EN
    send_req(1'b1, 3'd6, 3'd3);
    wr_valid = 1'b1; wr_data = 32'h1; #1;
    chk("b_err",       32'(err),       32'd1);
    chk("b_req_ready", 32'(req_ready), 32'd1);
    chk("b_wr_ready",  32'(wr_ready),  32'd0);
    chk("b_we",        32'(ram_we),    32'd0);
    chk("b_done",      32'(done),      32'd0);
    tick(); wr_valid = 1'b0; #1;
    chk("b_err_pulse", 32'(err),       32'd0);
    chk("b_no_writes", 32'(wr_count - base), 32'd0);
`else
    send_req(1'b1, 3'd6, 3'd3);
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'(16 + i); #1;
      chk("wrap_we",   32'(ram_we),   32'd1);
      chk("wrap_addr", 32'(ram_addr), 32'((6 + i) % 8));
      chk("wrap_err",  32'(err),      32'd0);
      tick();
    end
    wr_valid = 1'b0; #1;
    chk("wrap_done",   32'(done), 32'd1);
    chk("wrap_writes", 32'(wr_count - base), 32'd4);
    chk("wrap_mem0",   mem[0], 32'd18);
    chk("wrap_mem1",   mem[1], 32'd19);
    tick(); #1;
`endif

    // Write len=1 with wr_valid pattern 1,0,0,1
    base = wr_count;
    send_req(1'b1, 3'd0, 3'd1);
    wr_valid = 1'b1; wr_data = 32'h11; #1;
    chk("gap_we0",   32'(ram_we),   32'd1);
    chk("gap_addr0", 32'(ram_addr), 32'd0);
    tick(); wr_valid = 1'b0; wr_data = 32'hDEAD; #1;
    chk("gap_stall_we0", 32'(ram_we),   32'd0);
    chk("gap_stall_rdy", 32'(wr_ready), 32'd1);
    tick(); #1;
    chk("gap_stall_we1", 32'(ram_we),   32'd0);
    chk("gap_stall_addr", 32'(ram_addr), 32'd1);
    tick(); wr_valid = 1'b1; wr_data = 32'h22; #1;
    chk("gap_we1",   32'(ram_we),   32'd1);
    chk("gap_addr1", 32'(ram_addr), 32'd1);
    chk("gap_done_early", 32'(done), 32'd0);
    tick(); wr_valid = 1'b0; #1;
    chk("gap_done",   32'(done), 32'd1);
    chk("gap_writes", 32'(wr_count - base), 32'd2);
    chk("gap_mem0",   mem[0], 32'h11);
    chk("gap_mem1",   mem[1], 32'h22);
    tick(); #1;

    // Reset after the first of four write beats abandons the burst
    base = wr_count;
    send_req(1'b1, 3'd3, 3'd3);
    wr_valid = 1'b1; wr_data = 32'h55;
    tick();
    reset = 1'b1; wr_data = 32'h66; #1;
    chk("rb_we_in_reset", 32'(ram_we), 32'd0);
    tick(); #1;
    chk("rb_we_reset",   32'(ram_we),    32'd0);
    chk("rb_req_ready",  32'(req_ready), 32'd0);
    chk("rb_wr_ready",   32'(wr_ready),  32'd0);
    chk("rb_done",       32'(done),      32'd0);
    chk("rb_ram_addr",   32'(ram_addr),  32'd0);
    reset = 1'b0; wr_valid = 1'b0;
    tick(); #1;
    chk("rb_req_ready1", 32'(req_ready), 32'd1);
    chk("rb_done1",      32'(done),      32'd0);
    chk("rb_writes",     32'(wr_count - base), 32'd1);

    // Read back addr=3 len=1: first beat written before reset, second untouched
    rd_ready = 1'b1;
    send_req(1'b0, 3'd3, 3'd1);
    tick(); #1;
    chk("rb_rd0",   rd_data,       32'h55);
    chk("rb_last0", 32'(rd_last),  32'd0);
    tick(); tick(); #1;
    chk("rb_rd1",   rd_data,       32'hC);
    chk("rb_last1", 32'(rd_last),  32'd1);
    tick(); #1;
    chk("rb_rd_done", 32'(done), 32'd1);
    chk("rb_rd_err",  32'(err),  32'd0);
    rd_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sync_access_ctrl.md
RAM_SYNC_ACCESS_CTRL -- requirements
Module: ram_sync_access_ctrl

Interface
REQ-001 Parameters SHALL be: AWIDTH, 3, RAM address width (DEPTH = 1<<AWIDTH); DWIDTH, 32, data width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be as follows:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  burst request valid
- req_ready  out  1  controller idle, request accepted
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  AWIDTH  burst start address
- req_len  in  AWIDTH  beats minus one (0..DEPTH-1)
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted
- wr_data  in  DWIDTH  write beat data
- rd_valid  out  1  read beat valid
- rd_ready  in  1  read beat consumed
- rd_data  out  DWIDTH  read beat data
- rd_last  out  1  final read beat
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse on rejected request
- ram_addr  out  AWIDTH  to RAM addr
- ram_din  out  DWIDTH  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DWIDTH  from RAM dout, valid the cycle after ram_addr is presented

Function
REQ-004 FSM states SHALL be IDLE, WRITE, RD_ADDR, RD_RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, latch addr/len/write; cur_addr=req_addr, beat count=0.
REQ-006 Accepted write SHALL go to WRITE; accepted read SHALL go to RD_ADDR.
REQ-007 In WRITE: wr_ready=1, ram_addr=cur_addr, ram_din=wr_data, ram_we=wr_valid; each accepted beat increments cur_addr and count.
REQ-008 In WRITE, the beat with count==len SHALL pulse done next cycle and return to IDLE; wr_valid low stalls without RAM write.
REQ-009 In RD_ADDR: ram_addr=cur_addr, ram_we=0, rd_valid=0; unconditionally to RD_RESP next cycle.
REQ-010 In RD_RESP: ram_addr held at cur_addr, rd_valid=1, rd_data=ram_dout, rd_last=(count==len); data SHALL stay stable while rd_ready=0.
REQ-011 On rd_valid&&rd_ready: if last, pulse done and go IDLE; else cur_addr+1, count+1, go RD_ADDR.
REQ-012 Read latency: first rd_valid 2 cycles after request acceptance; max read throughput 1 beat per 2 cycles; write throughput 1 beat per cycle.
REQ-013 ram_we SHALL be 0 in every state except WRITE; wr_ready SHALL be 0 outside WRITE.
REQ-014 cur_addr increments SHALL be modulo DEPTH (AWIDTH-bit wrap) unless rejected per REQ-018.
REQ-015 done and err SHALL never assert in the same cycle.

Reset
REQ-016 reset high SHALL force IDLE, req_ready=0, wr_ready=0, rd_valid=0, rd_last=0, done=0, err=0, ram_we=0, ram_addr=0, ram_din=0, count=0.
REQ-017 Reset mid-burst SHALL abandon the burst with no done, no further RAM write; req_ready=1 the cycle after reset deasserts.

Configuration
REQ-018 With RAM_CTRL_BOUNDS_EN defined: a request where req_addr+req_len > DEPTH-1 (computed AWIDTH+1 bits) SHALL be accepted, pulse err next cycle, remain IDLE, cause no RAM access.
REQ-019 Without RAM_CTRL_BOUNDS_EN: err SHALL be tied 0 and bursts wrap at DEPTH per REQ-014.

Verification
REQ-020 Write addr=2 len=2 data 0xA,0xB,0xC back-to-back -> ram_we 3 consecutive cycles at addr 2,3,4; done 1 cycle after third beat.
REQ-021 Read addr=2 len=2 after REQ-020, rd_ready=1 -> rd_data 0xA,0xB,0xC, rd_last only on 0xC, rd_valid every other cycle, done once.
REQ-022 Read len=0 with rd_ready=0 for 5 cycles -> rd_valid held, rd_data stable, no done until rd_ready=1.
REQ-023 Write addr=6 len=3 (AWIDTH=3): with macro -> err pulse, zero ram_we; without -> writes at 6,7,0,1, done.
REQ-024 Reset asserted after 1 of 4 write beats -> no done, ram_we=0 during reset, req_ready=1 the cycle after release.
REQ-025 Write with wr_valid gaps (1,0,0,1) len=1 -> exactly 2 RAM writes at consecutive addresses, done after second.
